// File: rtl/sr_latch_driver.sv
// -----------------------------------------------------------------------------
// sr_latch_driver
//
// Turns two raw, asynchronous request levels (set / clear pushbuttons) into
// clean, mutually exclusive set and reset pulses for a downstream NOR SR latch.
//
// Each request input goes through this path:
//   two-flop synchroniser -> debouncer -> rising-edge event
// The events then drive a small pulse FSM (IDLE / SET_P / CLR_P / GAP).
//
// Parameters
//   DEBOUNCE_CYCLES : consecutive disagreeing cycles needed before a debounced
//                     level follows its input (1..255)
//   PULSE_CYCLES    : width of each s or r pulse in clock cycles (1..15)
//
// Ports
//   clk      : single clock; all state changes on the rising edge
//   rst_n    : asynchronous, active-low reset
//   set_req  : raw set request level
//   clr_req  : raw clear request level
//   s        : registered set pulse to the latch
//   r        : registered reset pulse to the latch
//   q_mirror : registered copy of the latch state the driver has commanded
//   busy     : high while the FSM is outside IDLE
//   conflict : one-cycle pulse when simultaneous set and clear were discarded
//
// Latency from the first edge that samples a stable high request to the first
// cycle of the pulse is DEBOUNCE_CYCLES+4 edges: 2 synchroniser flops,
// DEBOUNCE_CYCLES debounce cycles, 1 event register, 1 output register.
// -----------------------------------------------------------------------------
module sr_latch_driver #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned PULSE_CYCLES    = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic set_req,
  input  logic clr_req,
  output logic s,
  output logic r,
  output logic q_mirror,
  output logic busy,
  output logic conflict
);

  // Channel indices into the per-input vectors.
  localparam int CH_SET = 0;
  localparam int CH_CLR = 1;

  // Terminal values: the counter "reaches" the target on the cycle it would
  // otherwise step past the last value.
  localparam logic [7:0] DEB_LAST   = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0] PULSE_LAST = 4'(PULSE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SET_P = 2'd1,
    CLR_P = 2'd2,
    GAP   = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Input conditioning: one identical channel per request input.
  // ---------------------------------------------------------------------------
  logic [1:0] req_raw;
  logic [1:0] req_evt;

  assign req_raw[CH_SET] = set_req;
  assign req_raw[CH_CLR] = clr_req;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_chan
      logic       sync1_reg;
      logic       sync2_reg;
      logic       deb_reg;
      logic       deb_prev_reg;
      logic       evt_reg;
      logic [7:0] cnt_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sync1_reg    <= 1'b0;
          sync2_reg    <= 1'b0;
          deb_reg      <= 1'b0;
          deb_prev_reg <= 1'b0;
          evt_reg      <= 1'b0;
          cnt_reg      <= '0;
        end else begin
          sync1_reg <= req_raw[gi];
          sync2_reg <= sync1_reg;

          // The counter measures how long the synchronised level has
          // disagreed with the debounced one; any agreement restarts it.
          if (sync2_reg == deb_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == DEB_LAST) begin
            deb_reg <= ~deb_reg;
            cnt_reg <= '0;
          end else begin
            cnt_reg <= cnt_reg + 8'd1;
          end

          // Only rising edges of the debounced level become events.
          deb_prev_reg <= deb_reg;
          evt_reg      <= deb_reg & ~deb_prev_reg;
        end
      end

      assign req_evt[gi] = evt_reg;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Pulse FSM
  // ---------------------------------------------------------------------------
  state_t     state_reg,    state_next;
  logic [3:0] pcnt_reg,     pcnt_next;
  logic       pend_set_reg, pend_set_next;
  logic       pend_clr_reg, pend_clr_next;
  logic       q_reg,        q_next;
  logic       conflict_reg, conflict_next;
  logic       s_reg;
  logic       r_reg;
  logic       busy_reg;

  // Requests visible in IDLE: pending flags merged with live events. Merging
  // means a pending request always takes effect in the first IDLE cycle, and
  // a pending request of one type plus a live one of the other is a conflict.
  logic set_any;
  logic clr_any;

  assign set_any = req_evt[CH_SET] | pend_set_reg;
  assign clr_any = req_evt[CH_CLR] | pend_clr_reg;

  always_comb begin
    state_next    = state_reg;
    pcnt_next     = pcnt_reg;
    pend_set_next = pend_set_reg;
    pend_clr_next = pend_clr_reg;
    q_next        = q_reg;
    conflict_next = 1'b0;

    case (state_reg)
      IDLE: begin
        if (set_any && clr_any) begin
          // Ambiguous intent: drop both and flag it, latch untouched.
          conflict_next = 1'b1;
          pend_set_next = 1'b0;
          pend_clr_next = 1'b0;
        end else if (set_any) begin
          pend_set_next = 1'b0;
          // A set while already set is consumed silently.
          if (!q_reg) begin
            state_next = SET_P;
            pcnt_next  = '0;
            q_next     = 1'b1;
          end
        end else if (clr_any) begin
          pend_clr_next = 1'b0;
          if (q_reg) begin
            state_next = CLR_P;
            pcnt_next  = '0;
            q_next     = 1'b0;
          end
        end
      end

      SET_P, CLR_P: begin
        pend_set_next = pend_set_reg | req_evt[CH_SET];
        pend_clr_next = pend_clr_reg | req_evt[CH_CLR];
        if (pcnt_reg == PULSE_LAST) begin
          state_next = GAP;
        end else begin
          pcnt_next = pcnt_reg + 4'd1;
        end
      end

      GAP: begin
        // One dead cycle so s and r never touch back to back.
        pend_set_next = pend_set_reg | req_evt[CH_SET];
        pend_clr_next = pend_clr_reg | req_evt[CH_CLR];
        state_next    = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      pcnt_reg     <= '0;
      pend_set_reg <= 1'b0;
      pend_clr_reg <= 1'b0;
      q_reg        <= 1'b0;
      conflict_reg <= 1'b0;
      s_reg        <= 1'b0;
      r_reg        <= 1'b0;
      busy_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pcnt_reg     <= pcnt_next;
      pend_set_reg <= pend_set_next;
      pend_clr_reg <= pend_clr_next;
      q_reg        <= q_next;
      conflict_reg <= conflict_next;
      // Outputs are decoded from the next state so they are glitch-free
      // registers that line up exactly with the state they describe.
      s_reg        <= (state_next == SET_P);
      r_reg        <= (state_next == CLR_P);
      busy_reg     <= (state_next != IDLE);
    end
  end

  assign s        = s_reg;
  assign r        = r_reg;
  assign q_mirror = q_reg;
  assign busy     = busy_reg;
  assign conflict = conflict_reg;

endmodule

// File: tb/tb_sr_latch_driver.sv
// -----------------------------------------------------------------------------
// tb_sr_latch_driver
//
// Directed scenarios for sr_latch_driver with DEBOUNCE_CYCLES=4,
// PULSE_CYCLES=2. A behavioural model predicts every output on every cycle;
// hand-computed literal checks pin the model's key timings.
//
// Edge numbering in the comments: edge 1 is the first rising edge that
// samples a newly driven input level.
// -----------------------------------------------------------------------------
module tb_sr_latch_driver;

  localparam int D = 4;
  localparam int P = 2;

  logic clk      = 1'b0;
  logic rst_n    = 1'b0;
  logic set_req  = 1'b0;
  logic clr_req  = 1'b0;
  logic s;
  logic r;
  logic q_mirror;
  logic busy;
  logic conflict;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  sr_latch_driver #(
    .DEBOUNCE_CYCLES(D),
    .PULSE_CYCLES   (P)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .set_req (set_req),
    .clr_req (clr_req),
    .s       (s),
    .r       (r),
    .q_mirror(q_mirror),
    .busy    (busy),
    .conflict(conflict)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ---------------------------------------------------------------------------
  // Behavioural model
  //   Input side: the raw sample history is kept as a queue (newest first).
  //   The conditioned view at an edge is the raw sample from two edges
  //   earlier; the debounced level flips once the last D conditioned samples
  //   all disagree with it. A rise becomes visible to the pulse logic two
  //   edges after the flip.
  //   Pulse side: "pulse cycles left", a gap flag, the commanded latch state
  //   and one pending bit per request type.
  // ---------------------------------------------------------------------------
  bit m_raw_s[$];
  bit m_raw_c[$];
  bit m_deb_s, m_deb_c;
  bit m_rise1_s, m_rise1_c, m_rise2_s, m_rise2_c;
  bit m_q, m_set_kind, m_gap, m_conflict, m_pend_s, m_pend_c;
  int m_pulse_left;

  function automatic bit all_differ(input bit hist[$], input bit lvl);
    for (int i = 2; i < D + 2; i++) begin
      if (hist[i] == lvl) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_raw_s.delete();
    m_raw_c.delete();
    for (int i = 0; i < D + 2; i++) begin
      m_raw_s.push_back(1'b0);
      m_raw_c.push_back(1'b0);
    end
    m_deb_s = 0; m_deb_c = 0;
    m_rise1_s = 0; m_rise1_c = 0; m_rise2_s = 0; m_rise2_c = 0;
    m_q = 0; m_set_kind = 0; m_gap = 0; m_conflict = 0;
    m_pend_s = 0; m_pend_c = 0;
    m_pulse_left = 0;
  endtask

  task automatic model_step(input bit si, input bit ci);
    bit es;
    bit ec;
    bit rise_s;
    bit rise_c;
    es = m_rise2_s;
    ec = m_rise2_c;
    m_conflict = 0;
    if (m_pulse_left > 0) begin
      m_pend_s = m_pend_s | es;
      m_pend_c = m_pend_c | ec;
      m_pulse_left--;
      if (m_pulse_left == 0) m_gap = 1;
    end else if (m_gap) begin
      m_pend_s = m_pend_s | es;
      m_pend_c = m_pend_c | ec;
      m_gap = 0;
    end else begin
      es = es | m_pend_s;
      ec = ec | m_pend_c;
      if (es && ec) begin
        m_conflict = 1;
        m_pend_s = 0;
        m_pend_c = 0;
      end else if (es) begin
        m_pend_s = 0;
        if (!m_q) begin
          m_q = 1; m_set_kind = 1; m_pulse_left = P;
        end
      end else if (ec) begin
        m_pend_c = 0;
        if (m_q) begin
          m_q = 0; m_set_kind = 0; m_pulse_left = P;
        end
      end
    end

    m_raw_s.push_front(si);
    m_raw_c.push_front(ci);
    rise_s = 0;
    rise_c = 0;
    if (all_differ(m_raw_s, m_deb_s)) begin
      m_deb_s = !m_deb_s;
      rise_s  = m_deb_s;
    end
    if (all_differ(m_raw_c, m_deb_c)) begin
      m_deb_c = !m_deb_c;
      rise_c  = m_deb_c;
    end
    void'(m_raw_s.pop_back());
    void'(m_raw_c.pop_back());
    m_rise2_s = m_rise1_s; m_rise1_s = rise_s;
    m_rise2_c = m_rise1_c; m_rise1_c = rise_c;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step(set_req, clr_req);
    end
  end

  // ---------------------------------------------------------------------------
  // Checking helpers
  // ---------------------------------------------------------------------------
  task automatic expect_bit(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d: got %b, want %b", name, cyc, act, exp);
    end
  endtask

  task automatic expect_int(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d: got %0d, want %0d", name, cyc, act, exp);
    end
  endtask

  // Per-cycle comparison against the model: {s, r, q_mirror, busy, conflict}.
  logic [4:0] exp_vec;
  logic [4:0] act_vec;

  initial forever begin
    @(negedge clk);
    exp_vec = {(m_pulse_left > 0) && m_set_kind,
               (m_pulse_left > 0) && !m_set_kind,
               m_q,
               (m_pulse_left > 0) || m_gap,
               m_conflict};
    act_vec = {s, r, q_mirror, busy, conflict};
    n_vec++;
    if (act_vec !== exp_vec) begin
      n_err++;
      $display("FAIL model_cmp cyc=%0d: got s,r,q,busy,conflict=%b, want %b",
               cyc, act_vec, exp_vec);
    end
    expect_bit("s_r_exclusive", s & r, 1'b0);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  int busy_hi;
  int s_hi;
  int r_hi;

  initial begin
    // Reset state.
    tick(3);
    expect_bit("rst_s", s, 1'b0);
    expect_bit("rst_r", r, 1'b0);
    expect_bit("rst_q", q_mirror, 1'b0);
    expect_bit("rst_busy", busy, 1'b0);
    expect_bit("rst_conflict", conflict, 1'b0);
    rst_n = 1'b1;
    tick(2);
    $display("scenario reset done");

    // Set held high: s rises after edge D+4=8, lasts 2 cycles, busy 3 cycles.
    set_req = 1'b1;
    tick(D + 3);
    expect_bit("set_before_latency", s, 1'b0);
    tick(1);
    expect_bit("set_at_latency", s, 1'b1);
    expect_bit("set_q", q_mirror, 1'b1);
    expect_bit("set_r_low", r, 1'b0);
    busy_hi = busy;
    s_hi    = s;
    repeat (5) begin
      tick(1);
      busy_hi += busy;
      s_hi    += s;
    end
    expect_int("set_s_width", s_hi, 2);
    expect_int("set_busy_width", busy_hi, 3);
    set_req = 1'b0;
    tick(12);
    $display("scenario set_hold done");

    // Second set while already set: consumed, no pulse, busy stays low.
    set_req = 1'b1;
    busy_hi = 0;
    s_hi    = 0;
    repeat (14) begin
      tick(1);
      busy_hi += busy;
      s_hi    += s;
    end
    expect_int("reset_while_set_busy", busy_hi, 0);
    expect_int("reset_while_set_s", s_hi, 0);
    expect_bit("reset_while_set_q", q_mirror, 1'b1);
    set_req = 1'b0;
    tick(12);
    $display("scenario set_while_set done");

    // Simultaneous set and clear with q_mirror=1: conflict for one cycle.
    set_req = 1'b1;
    clr_req = 1'b1;
    tick(D + 4);
    expect_bit("conflict_pulse", conflict, 1'b1);
    expect_bit("conflict_s", s, 1'b0);
    expect_bit("conflict_r", r, 1'b0);
    expect_bit("conflict_busy", busy, 1'b0);
    tick(1);
    expect_bit("conflict_one_cycle", conflict, 1'b0);
    expect_bit("conflict_q_kept", q_mirror, 1'b1);
    set_req = 1'b0;
    clr_req = 1'b0;
    tick(12);
    $display("scenario conflict done");

    // Plain clear: r for 2 cycles, q_mirror drops with the first.
    clr_req = 1'b1;
    tick(D + 4);
    expect_bit("clr_r", r, 1'b1);
    expect_bit("clr_q", q_mirror, 1'b0);
    expect_bit("clr_s", s, 1'b0);
    tick(1);
    expect_bit("clr_r_2nd", r, 1'b1);
    tick(1);
    expect_bit("clr_gap_r", r, 1'b0);
    expect_bit("clr_gap_busy", busy, 1'b1);
    clr_req = 1'b0;
    tick(12);
    $display("scenario clear done");

    // Glitches of 3 cycles, separated by 1 low cycle: the counter must
    // restart, so the debounced level never flips.
    set_req = 1'b1; tick(3);
    set_req = 1'b0; tick(1);
    set_req = 1'b1; tick(3);
    set_req = 1'b0;
    busy_hi = 0;
    s_hi    = 0;
    repeat (15) begin
      tick(1);
      busy_hi += busy;
      s_hi    += s;
    end
    expect_int("glitch_s", s_hi, 0);
    expect_int("glitch_busy", busy_hi, 0);
    expect_bit("glitch_q", q_mirror, 1'b0);
    $display("scenario glitch done");

    // Clear arriving during SET_P: set first sampled at edge 1, clear at
    // edge 2. s high after edges 8-9, GAP after 10, IDLE after 11, r high
    // after edges 12-13.
    set_req = 1'b1;
    tick(1);
    clr_req = 1'b1;
    tick(D + 3);
    expect_bit("pend_s_on", s, 1'b1);
    s_hi = 0;
    r_hi = 0;
    tick(3);
    expect_bit("pend_idle_between", busy, 1'b0);
    tick(1);
    expect_bit("pend_r_on", r, 1'b1);
    expect_bit("pend_q_cleared", q_mirror, 1'b0);
    tick(1);
    expect_bit("pend_r_2nd", r, 1'b1);
    tick(1);
    expect_bit("pend_r_off", r, 1'b0);
    set_req = 1'b0;
    clr_req = 1'b0;
    tick(12);
    $display("scenario clear_during_set done");

    // Reset in the 2nd cycle of SET_P, then release with set_req still high.
    set_req = 1'b1;
    tick(D + 4);
    expect_bit("rstmid_s_on", s, 1'b1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    expect_bit("rstmid_s_drop", s, 1'b0);
    expect_bit("rstmid_q_drop", q_mirror, 1'b0);
    expect_bit("rstmid_busy_drop", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(D + 3);
    expect_bit("rstmid_before_latency", s, 1'b0);
    tick(1);
    expect_bit("rstmid_fresh_s", s, 1'b1);
    expect_bit("rstmid_fresh_q", q_mirror, 1'b1);
    tick(4);
    set_req = 1'b0;
    tick(12);
    $display("scenario reset_mid_pulse done");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
